mitch_prod_accumulator: RTL and testbench

- Streaming accumulator directly downstream of the 16x16 approximate logarithmic multiplier. It consumes the 32-bit signed product stream `p` and sums each vector of products into one wide dot-product result.
- Valid/ready handshakes on both sides.
- The result is held until the consumer accepts it.
- Used to turn the combinational multiplier into a dot-product/MAC engine for error-resilient workloads.

---
 rtl/mitch_prod_accumulator.sv | 102 ++++++++++
 tb/tb_mitch_prod_accumulator.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mitch_prod_accumulator.sv
// Streaming dot-product accumulator for the approximate log multiplier's product stream.
// Optional clamping on signed overflow is enabled by defining MITCH_ACC_SATURATE_EN.
module mitch_prod_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_data_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_LEN = '1;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   sum;
    logic               sum_ovf;
    logic               accept;

    assign addend  = {{(ACC_W-32){in_data_i[31]}}, in_data_i};
    assign sum     = acc_q + addend;
    assign sum_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    assign in_ready_o  = (state_q != HOLD);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == HOLD);
    assign out_data_o  = acc_q;
    assign out_count_o = count_q;
    assign out_ovf_o   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = addend;
                    count_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (in_last_i || count_d == MAX_LEN) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = sum;
`ifdef MITCH_ACC_SATURATE_EN
                    // Clamp toward the addend's sign; later additions start from the rail.
                    if (sum_ovf) begin
                        acc_d = addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                : {1'b0, {(ACC_W-1){1'b1}}};
                    end
`endif
                    count_d = count_q + CNT_W'(1);
                    ovf_d   = ovf_q | sum_ovf;
                    state_d = (in_last_i || count_d == MAX_LEN) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mitch_prod_accumulator.sv
// Scoreboard bench: a default-width instance and a narrow (ACC_W=33, CNT_W=2) instance
// share one stimulus driver; per-instance monitors compare results against queued expectations.
module tb_mitch_prod_accumulator;

    localparam int A0 = 40;
    localparam int C0 = 8;
    localparam int A1 = 33;
    localparam int C1 = 2;

    typedef struct {
        logic [63:0] data;
        int          count;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_errors = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic          in_ready0, out_valid0, out_ovf0;
    logic [A0-1:0] out_data0;
    logic [C0-1:0] out_count0;
    logic          in_ready1, out_valid1, out_ovf1;
    logic [A1-1:0] out_data1;
    logic [C1-1:0] out_count1;

    logic in_valid0, in_valid1, ready_sel;
    assign in_valid0 = in_valid && !sel;
    assign in_valid1 = in_valid && sel;
    assign ready_sel = sel ? in_ready1 : in_ready0;

    always #5 clk = ~clk;

    mitch_prod_accumulator #(.ACC_W(A0), .CNT_W(C0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .out_data_o(out_data0), .out_count_o(out_count0), .out_ovf_o(out_ovf0)
    );

    mitch_prod_accumulator #(.ACC_W(A1), .CNT_W(C1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .out_data_o(out_data1), .out_count_o(out_count1), .out_ovf_o(out_ovf1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit which, input logic [63:0] d, input int c, input logic o);
        exp_t e;
        e.data = d;
        e.count = c;
        e.ovf = o;
        if (which) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic applyStimulus(input logic [31:0] d, input logic l);
        int waitc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waitc    = 0;
        forever begin
            @(negedge clk);
            if (ready_sel) break;
            waitc++;
            if (waitc > 50) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL accept timeout: in_ready stayed 0 for data 0x%0h", d);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid0) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL dut0 unexpected result: got 0x%0h, expected none", out_data0);
            end else begin
                check("dut0 data", 64'(out_data0), q0[0].data);
                check("dut0 count", 64'(out_count0), 64'(q0[0].count));
                check("dut0 ovf", 64'(out_ovf0), 64'(q0[0].ovf));
                if (out_ready) q0.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL dut1 unexpected result: got 0x%0h, expected none", out_data1);
            end else begin
                check("dut1 data", 64'(out_data1), q1[0].data);
                check("dut1 count", 64'(out_count1), 64'(q1[0].count));
                check("dut1 ovf", 64'(out_ovf1), 64'(q1[0].ovf));
                if (out_ready) q1.delete(0);
            end
        end
    end

    initial begin
        int bub;
        int drain;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset in_ready0", 64'(in_ready0), 64'd1);
        check("reset out_valid0", 64'(out_valid0), 64'd0);
        check("reset out_data0", 64'(out_data0), 64'd0);
        check("reset out_count0", 64'(out_count0), 64'd0);
        check("reset out_ovf0", 64'(out_ovf0), 64'd0);
        check("reset in_ready1", 64'(in_ready1), 64'd1);
        check("reset out_valid1", 64'(out_valid1), 64'd0);
        @(posedge clk); #1;

        // Basic sum with a one-cycle bubble
        sel = 1'b0;
        out_ready = 1'b1;
        push(0, 64'd77, 3, 1'b0);
        applyStimulus(32'd100, 1'b0);
        applyStimulus(32'hFFFF_FFE2, 1'b0);
        applyStimulus(32'd7, 1'b1);
        bub = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!in_ready0) bub++;
            @(posedge clk); #1;
        end
        check("bubble cycles", 64'(bub), 64'd1);

        // Backpressure holds the result and blocks input
        out_ready = 1'b0;
        push(0, 64'd11, 2, 1'b0);
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold in_ready0", 64'(in_ready0), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push(0, 64'd1, 1, 1'b0);
        applyStimulus(32'd1, 1'b1);
        idle(3);

        // Zero elements count; idle gaps inside a vector are harmless
        push(0, 64'd0, 2, 1'b0);
        applyStimulus(32'd0, 1'b0);
        applyStimulus(32'd0, 1'b1);
        push(0, 64'd7, 2, 1'b0);
        applyStimulus(32'd3, 1'b0);
        idle(2);
        applyStimulus(32'd4, 1'b1);
        idle(3);

        // Negative single element
        push(0, 64'h00_0000_00FF_FFFF_8000, 1, 1'b0);
        applyStimulus(32'hFFFF_8000, 1'b1);
        idle(3);

        // Reset mid-vector discards the partial sum
        applyStimulus(32'd50, 1'b0);
        applyStimulus(32'd60, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, 64'd9, 1, 1'b0);
        applyStimulus(32'd9, 1'b1);
        idle(3);

        // Reset while holding a result
        out_ready = 1'b0;
        push(0, 64'd4, 1, 1'b0);
        applyStimulus(32'd4, 1'b1);
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (q0.size() > 0) q0.delete(0);
        @(negedge clk);
        check("hold-reset out_valid0", 64'(out_valid0), 64'd0);
        check("hold-reset in_ready0", 64'(in_ready0), 64'd1);
        check("hold-reset out_data0", 64'(out_data0), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Forced termination at MAX_LEN=3 on the narrow instance
        sel = 1'b1;
        out_ready = 1'b0;
        push(1, 64'd3, 3, 1'b0);
        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'd1, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("forced in_ready1", 64'(in_ready1), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push(1, 64'd1, 1, 1'b0);
        applyStimulus(32'd1, 1'b1);
        idle(3);

        // Positive and negative overflow at ACC_W=33
`ifdef MITCH_ACC_SATURATE_EN
        push(1, 64'h0_FFFF_FFFF, 3, 1'b1);
`else
        push(1, 64'h1_7FFF_FFFD, 3, 1'b1);
`endif
        applyStimulus(32'h7FFF_FFFF, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 1'b1);
        idle(3);
`ifdef MITCH_ACC_SATURATE_EN
        push(1, 64'h1_0000_0000, 3, 1'b1);
`else
        push(1, 64'h0_8000_0000, 3, 1'b1);
`endif
        applyStimulus(32'h8000_0000, 1'b0);
        applyStimulus(32'h8000_0000, 1'b0);
        applyStimulus(32'h8000_0000, 1'b1);
        idle(3);
        push(1, 64'd2, 1, 1'b0);
        applyStimulus(32'd2, 1'b1);
        idle(3);

        drain = 0;
        while ((q0.size() != 0 || q1.size() != 0) && drain < 20) begin
            @(posedge clk); #1;
            drain++;
        end
        check("dut0 queue drained", 64'(q0.size()), 64'd0);
        check("dut1 queue drained", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
